// File: rtl/eth_mgmt_csr_pkg.sv
// Shared definitions for the Ethernet management CSR bridge: CSR byte offsets,
// CMD/STATUS field positions and the transaction FSM state type.
package eth_mgmt_csr_pkg;

  localparam logic [15:0] OFF_DFH     = 16'h0000;
  localparam logic [15:0] OFF_ID_L    = 16'h0008;
  localparam logic [15:0] OFF_ID_H    = 16'h0010;
  localparam logic [15:0] OFF_CMD     = 16'h0028;
  localparam logic [15:0] OFF_WR_DATA = 16'h0030;
  localparam logic [15:0] OFF_RD_DATA = 16'h0038;
  localparam logic [15:0] OFF_STATUS  = 16'h0040;
  localparam logic [15:0] OFF_SCRATCH = 16'h0048;
  localparam logic [15:0] OFF_TIMEOUT = 16'h0050;

  localparam logic [63:0] DFH_VALUE = 64'h1000_0000_0000_0001;

  localparam int unsigned CMD_CH_LSB = 16;
  localparam int unsigned CMD_CH_W   = 8;
  localparam int unsigned CMD_RD_BIT = 24;
  localparam int unsigned CMD_WR_BIT = 25;

  localparam int unsigned STS_BUSY     = 0;
  localparam int unsigned STS_DONE     = 1;
  localparam int unsigned STS_ERR_TO   = 2;
  localparam int unsigned STS_ERR_BUSY = 3;
  localparam int unsigned STS_ERR_CMD  = 4;
  localparam int unsigned STS_CNT_LSB  = 32;
  localparam int unsigned STS_CNT_W    = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } txn_state_e;

  // 8-byte CSR index as seen on mmio_addr[15:1] (mmio_addr is a 4-byte address)
  function automatic logic [14:0] csr_idx(input logic [15:0] byte_off);
    return {3'b000, byte_off[15:3]};
  endfunction

endpackage

// File: rtl/eth_mgmt_txn_fsm.sv
// Single-outstanding management transaction engine: launches one read or write on
// the selected channel, waits out waitrequest, and reports completion or timeout.
module eth_mgmt_txn_fsm
  import eth_mgmt_csr_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid_i,
  input  logic [ADDR_W-1:0]        cmd_addr_i,
  input  logic [7:0]               cmd_ch_i,
  input  logic                     cmd_rd_i,
  input  logic                     cmd_wr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [31:0]              timeout_i,
  input  logic [NUM_CH-1:0]        mgmt_waitrequest_i,
  input  logic [NUM_CH*DATA_W-1:0] mgmt_readdata_i,
  output logic [ADDR_W-1:0]        mgmt_address_o,
  output logic [DATA_W-1:0]        mgmt_writedata_o,
  output logic [NUM_CH-1:0]        mgmt_read_o,
  output logic [NUM_CH-1:0]        mgmt_write_o,
  output logic                     busy_o,
  output logic                     evt_start_o,
  output logic                     evt_done_o,
  output logic                     evt_rd_done_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     evt_timeout_o,
  output logic                     evt_err_busy_o,
  output logic                     evt_err_cmd_o
);

  txn_state_e          state_q;
  logic [NUM_CH-1:0]   rd_q;
  logic [NUM_CH-1:0]   wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [31:0]         cyc_q;

  logic [NUM_CH-1:0]   ch_onehot;
  logic                cmd_ok;
  logic                in_busy;
  logic                act_wait;
  logic [DATA_W-1:0]   rdata_sel;

  // An all-zero one-hot means the requested channel is out of range
  always_comb begin
    ch_onehot = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ch_onehot[c] = (32'(cmd_ch_i) == c);
    end
  end

  always_comb begin
    rdata_sel = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rd_q[c]) rdata_sel = mgmt_readdata_i[c*DATA_W +: DATA_W];
    end
  end

  assign cmd_ok   = (|ch_onehot) && (cmd_rd_i ^ cmd_wr_i);
  assign in_busy  = (state_q == ST_BUSY);
  assign act_wait = |(mgmt_waitrequest_i & (rd_q | wr_q));

  assign evt_start_o    = cmd_valid_i && !in_busy && cmd_ok;
  assign evt_err_cmd_o  = cmd_valid_i && !in_busy && !cmd_ok;
  assign evt_err_busy_o = cmd_valid_i && in_busy;
  assign evt_done_o     = in_busy && !act_wait;
  assign evt_rd_done_o  = evt_done_o && (|rd_q);
  assign evt_timeout_o  = in_busy && act_wait && (timeout_i != '0) &&
                          ((cyc_q + 32'd1) == timeout_i);
  assign rd_data_o      = rdata_sel;
  assign busy_o         = in_busy;

  assign mgmt_address_o   = addr_q;
  assign mgmt_writedata_o = wdata_q;
  assign mgmt_read_o      = rd_q;
  assign mgmt_write_o     = wr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cyc_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (evt_start_o) begin
            state_q <= ST_BUSY;
            addr_q  <= cmd_addr_i;
            wdata_q <= wr_data_i;
            rd_q    <= cmd_rd_i ? ch_onehot : '0;
            wr_q    <= cmd_wr_i ? ch_onehot : '0;
            cyc_q   <= '0;
          end
        end
        ST_BUSY: begin
          if (evt_done_o || evt_timeout_o) begin
            state_q <= ST_IDLE;
            rd_q    <= '0;
            wr_q    <= '0;
          end else begin
            cyc_q <= cyc_q + 32'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rd_q    <= '0;
          wr_q    <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/eth_mgmt_csr_bridge.sv
// CCI-P MMIO CSR block fronting a set of Ethernet management channels: CSR decode,
// sticky status, two-stage read response pipeline, and the transaction engine.
module eth_mgmt_csr_bridge
  import eth_mgmt_csr_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_RST = 1024,
  parameter logic [63:0] AFU_ID_L    = 64'h0,
  parameter logic [63:0] AFU_ID_H    = 64'h0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mmio_wr_en,
  input  logic                     mmio_rd_en,
  input  logic [15:0]              mmio_addr,
  input  logic [63:0]              mmio_wdata,
  input  logic [8:0]               mmio_tid,
  output logic                     mmio_rsp_valid,
  output logic [8:0]               mmio_rsp_tid,
  output logic [63:0]              mmio_rsp_data,
  output logic [ADDR_W-1:0]        mgmt_address,
  output logic [DATA_W-1:0]        mgmt_writedata,
  output logic [NUM_CH-1:0]        mgmt_read,
  output logic [NUM_CH-1:0]        mgmt_write,
  input  logic [NUM_CH*DATA_W-1:0] mgmt_readdata,
  input  logic [NUM_CH-1:0]        mgmt_waitrequest
);

  localparam logic [14:0] IDX_DFH     = csr_idx(OFF_DFH);
  localparam logic [14:0] IDX_ID_L    = csr_idx(OFF_ID_L);
  localparam logic [14:0] IDX_ID_H    = csr_idx(OFF_ID_H);
  localparam logic [14:0] IDX_CMD     = csr_idx(OFF_CMD);
  localparam logic [14:0] IDX_WR_DATA = csr_idx(OFF_WR_DATA);
  localparam logic [14:0] IDX_RD_DATA = csr_idx(OFF_RD_DATA);
  localparam logic [14:0] IDX_STATUS  = csr_idx(OFF_STATUS);
  localparam logic [14:0] IDX_SCRATCH = csr_idx(OFF_SCRATCH);
  localparam logic [14:0] IDX_TIMEOUT = csr_idx(OFF_TIMEOUT);

  logic [14:0] acc_idx;
  logic        unused_addr_lsb;
  logic        cmd_wr;
  logic        sts_wr;

  logic [63:0] cmd_q;
  logic [63:0] wr_data_q;
  logic [63:0] rd_data_q;
  logic [63:0] scratch_q;
  logic [31:0] timeout_q;
  logic        done_q;
  logic        err_to_q;
  logic        err_busy_q;
  logic        err_cmd_q;
  logic [15:0] cnt_q;

  logic        rd_v1_q;
  logic [8:0]  rd_tid1_q;
  logic [14:0] rd_idx1_q;
  logic [63:0] status_val;
  logic [63:0] csr_rdata;

  logic              fsm_busy;
  logic              fsm_start;
  logic              fsm_done;
  logic              fsm_rd_done;
  logic [DATA_W-1:0] fsm_rd_data;
  logic              fsm_timeout;
  logic              fsm_err_busy;
  logic              fsm_err_cmd;

  assign acc_idx         = mmio_addr[15:1];
  assign unused_addr_lsb = mmio_addr[0];
  assign cmd_wr          = mmio_wr_en && (acc_idx == IDX_CMD);
  assign sts_wr          = mmio_wr_en && (acc_idx == IDX_STATUS);

  eth_mgmt_txn_fsm #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_txn_fsm (
    .clk                (clk),
    .reset_n            (reset_n),
    .cmd_valid_i        (cmd_wr),
    .cmd_addr_i         (mmio_wdata[ADDR_W-1:0]),
    .cmd_ch_i           (mmio_wdata[CMD_CH_LSB +: CMD_CH_W]),
    .cmd_rd_i           (mmio_wdata[CMD_RD_BIT]),
    .cmd_wr_i           (mmio_wdata[CMD_WR_BIT]),
    .wr_data_i          (wr_data_q[DATA_W-1:0]),
    .timeout_i          (timeout_q),
    .mgmt_waitrequest_i (mgmt_waitrequest),
    .mgmt_readdata_i    (mgmt_readdata),
    .mgmt_address_o     (mgmt_address),
    .mgmt_writedata_o   (mgmt_writedata),
    .mgmt_read_o        (mgmt_read),
    .mgmt_write_o       (mgmt_write),
    .busy_o             (fsm_busy),
    .evt_start_o        (fsm_start),
    .evt_done_o         (fsm_done),
    .evt_rd_done_o      (fsm_rd_done),
    .rd_data_o          (fsm_rd_data),
    .evt_timeout_o      (fsm_timeout),
    .evt_err_busy_o     (fsm_err_busy),
    .evt_err_cmd_o      (fsm_err_cmd)
  );

  always_comb begin
    status_val                           = '0;
    status_val[STS_BUSY]                 = fsm_busy;
    status_val[STS_DONE]                 = done_q;
    status_val[STS_ERR_TO]               = err_to_q;
    status_val[STS_ERR_BUSY]             = err_busy_q;
    status_val[STS_ERR_CMD]              = err_cmd_q;
    status_val[STS_CNT_LSB +: STS_CNT_W] = cnt_q;
  end

  // Muxed one cycle after the read strobe so same-cycle CSR writes are visible
  always_comb begin
    csr_rdata = '0;
    case (rd_idx1_q)
      IDX_DFH:     csr_rdata = DFH_VALUE;
      IDX_ID_L:    csr_rdata = AFU_ID_L;
      IDX_ID_H:    csr_rdata = AFU_ID_H;
      IDX_CMD:     csr_rdata = cmd_q;
      IDX_WR_DATA: csr_rdata = wr_data_q;
      IDX_RD_DATA: csr_rdata = rd_data_q;
      IDX_STATUS:  csr_rdata = status_val;
      IDX_SCRATCH: csr_rdata = scratch_q;
      IDX_TIMEOUT: csr_rdata = 64'(timeout_q);
      default:     csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q          <= '0;
      wr_data_q      <= '0;
      rd_data_q      <= '0;
      scratch_q      <= '0;
      timeout_q      <= 32'(TIMEOUT_RST);
      done_q         <= 1'b0;
      err_to_q       <= 1'b0;
      err_busy_q     <= 1'b0;
      err_cmd_q      <= 1'b0;
      cnt_q          <= '0;
      rd_v1_q        <= 1'b0;
      rd_tid1_q      <= '0;
      rd_idx1_q      <= '0;
      mmio_rsp_valid <= 1'b0;
      mmio_rsp_tid   <= '0;
      mmio_rsp_data  <= '0;
    end else begin
      if (mmio_wr_en) begin
        case (acc_idx)
          IDX_CMD:     cmd_q     <= mmio_wdata;
          IDX_WR_DATA: wr_data_q <= mmio_wdata;
          IDX_SCRATCH: scratch_q <= mmio_wdata;
          IDX_TIMEOUT: timeout_q <= mmio_wdata[31:0];
          default: ;
        endcase
      end

      // A new event in the same cycle as a write-1-to-clear keeps the bit set
      done_q     <= (done_q && !fsm_start) || fsm_done;
      err_to_q   <= (err_to_q   && !(sts_wr && mmio_wdata[STS_ERR_TO]))   || fsm_timeout;
      err_busy_q <= (err_busy_q && !(sts_wr && mmio_wdata[STS_ERR_BUSY])) || fsm_err_busy;
      err_cmd_q  <= (err_cmd_q  && !(sts_wr && mmio_wdata[STS_ERR_CMD]))  || fsm_err_cmd;
      if (fsm_done)    cnt_q     <= cnt_q + 16'd1;
      if (fsm_rd_done) rd_data_q <= 64'(fsm_rd_data);

      rd_v1_q <= mmio_rd_en;
      if (mmio_rd_en) begin
        rd_tid1_q <= mmio_tid;
        rd_idx1_q <= acc_idx;
      end
      mmio_rsp_valid <= rd_v1_q;
      if (rd_v1_q) begin
        mmio_rsp_tid  <= rd_tid1_q;
        mmio_rsp_data <= csr_rdata;
      end
    end
  end

endmodule

// File: tb/tb_eth_mgmt_csr_bridge.sv
// Directed bench for the management CSR bridge; MMIO read responses are checked
// against a scoreboard of expected tid/data/arrival cycle.
module tb_eth_mgmt_csr_bridge;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam logic [63:0] ID_L   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID_H   = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] DFH    = 64'h1000_0000_0000_0001;
  localparam logic [63:0] SCR    = 64'hDEAD_BEEF_1234_5678;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          due;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b1;
  logic                     mmio_wr_en = 1'b0;
  logic                     mmio_rd_en = 1'b0;
  logic [15:0]              mmio_addr = '0;
  logic [63:0]              mmio_wdata = '0;
  logic [8:0]               mmio_tid = '0;
  logic                     mmio_rsp_valid;
  logic [8:0]               mmio_rsp_tid;
  logic [63:0]              mmio_rsp_data;
  logic [ADDR_W-1:0]        mgmt_address;
  logic [DATA_W-1:0]        mgmt_writedata;
  logic [NUM_CH-1:0]        mgmt_read;
  logic [NUM_CH-1:0]        mgmt_write;
  logic [NUM_CH*DATA_W-1:0] mgmt_readdata = '0;
  logic [NUM_CH-1:0]        mgmt_waitrequest = '1;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_strobe;
  exp_t sbq[$];
  exp_t mon_e;

  eth_mgmt_csr_bridge #(
    .NUM_CH      (NUM_CH),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_RST (1024),
    .AFU_ID_L    (ID_L),
    .AFU_ID_H    (ID_H)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mmio_wr_en       (mmio_wr_en),
    .mmio_rd_en       (mmio_rd_en),
    .mmio_addr        (mmio_addr),
    .mmio_wdata       (mmio_wdata),
    .mmio_tid         (mmio_tid),
    .mmio_rsp_valid   (mmio_rsp_valid),
    .mmio_rsp_tid     (mmio_rsp_tid),
    .mmio_rsp_data    (mmio_rsp_data),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_read        (mgmt_read),
    .mgmt_write       (mgmt_write),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All stimulus tasks are entered on a falling edge and return on the next one
  task automatic wr(input logic [7:0] off, input logic [63:0] d);
    mmio_wr_en = 1'b1;
    mmio_addr  = 16'(off) >> 2;
    mmio_wdata = d;
    @(negedge clk);
    mmio_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, input logic [8:0] tid, input logic [63:0] exp);
    exp_t e;
    mmio_rd_en = 1'b1;
    mmio_addr  = 16'(off) >> 2;
    mmio_tid   = tid;
    e.tid  = tid;
    e.data = exp;
    e.due  = cyc + 2;
    sbq.push_back(e);
    @(negedge clk);
    mmio_rd_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    chk(tag, 64'(sbq.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (reset_n) chk("strobe_onehot0", 64'($onehot0(mgmt_read | mgmt_write)), 64'd1);
    if (mmio_rsp_valid) begin
      chk("rsp_expected", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("rsp_tid", 64'(mmio_rsp_tid), 64'(mon_e.tid));
        chk("rsp_data", mmio_rsp_data, mon_e.data);
        chk("rsp_latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(mmio_rsp_valid), 64'd0);
    chk("rst_rsp_tid", 64'(mmio_rsp_tid), 64'd0);
    chk("rst_rsp_data", mmio_rsp_data, 64'd0);
    chk("rst_mgmt_read", 64'(mgmt_read), 64'd0);
    chk("rst_mgmt_write", 64'(mgmt_write), 64'd0);
    chk("rst_mgmt_address", 64'(mgmt_address), 64'd0);
    chk("rst_mgmt_writedata", 64'(mgmt_writedata), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // CSR map and back-to-back reads
    rd(8'h40, 9'd20, 64'd0);
    rd(8'h50, 9'd21, 64'd1024);
    rd(8'h28, 9'd22, 64'd0);
    rd(8'h38, 9'd23, 64'd0);
    drain("drain_reset_csrs");
    wr(8'h48, SCR);
    wr(8'h20, 64'hFFFF_FFFF);
    rd(8'h00, 9'd1, DFH);
    rd(8'h08, 9'd2, ID_L);
    rd(8'h48, 9'd3, SCR);
    drain("drain_b2b");
    rd(8'h10, 9'd4, ID_H);
    rd(8'h20, 9'd5, 64'd0);
    rd(8'h58, 9'd6, 64'd0);
    drain("drain_map");

    // Read transaction on channel 0
    wr(8'h28, 64'h0100_0012);
    chk("rd_strobe", 64'(mgmt_read), 64'h1);
    chk("rd_no_write", 64'(mgmt_write), 64'h0);
    chk("rd_address", 64'(mgmt_address), 64'h12);
    repeat (2) begin
      @(negedge clk);
      chk("rd_strobe_hold", 64'(mgmt_read), 64'h1);
    end
    mgmt_readdata[0 +: DATA_W] = 32'hCAFE_F00D;
    mgmt_waitrequest[0] = 1'b0;
    @(negedge clk);
    chk("rd_strobe_drop", 64'(mgmt_read), 64'h0);
    mgmt_waitrequest = '1;
    mgmt_readdata    = '0;
    rd(8'h38, 9'd10, 64'hCAFE_F00D);
    rd(8'h40, 9'd11, 64'h1_0000_0002);
    rd(8'h28, 9'd12, 64'h0100_0012);
    drain("drain_rd_txn");

    // Write transaction on channel 3; WR_DATA update mid-flight must not leak
    wr(8'h30, 64'h55AA);
    wr(8'h28, 64'h0203_0040);
    chk("wr_strobe", 64'(mgmt_write), 64'h8);
    chk("wr_no_read", 64'(mgmt_read), 64'h0);
    chk("wr_address", 64'(mgmt_address), 64'h40);
    chk("wr_writedata", 64'(mgmt_writedata), 64'h55AA);
    wr(8'h30, 64'h1234);
    chk("wr_strobe_hold", 64'(mgmt_write), 64'h8);
    chk("wr_writedata_stable", 64'(mgmt_writedata), 64'h55AA);
    mgmt_waitrequest[3] = 1'b0;
    @(negedge clk);
    chk("wr_strobe_drop", 64'(mgmt_write), 64'h0);
    mgmt_waitrequest = '1;
    rd(8'h40, 9'd13, 64'h2_0000_0002);
    rd(8'h30, 9'd14, 64'h1234);
    drain("drain_wr_txn");

    // Timeout on channel 1
    wr(8'h50, 64'd8);
    wr(8'h28, 64'h0101_0000);
    n_strobe = 0;
    for (int i = 0; i < 40; i++) begin
      if (mgmt_read != 4'b0010) break;
      n_strobe++;
      @(negedge clk);
    end
    chk("timeout_strobe_cycles", 64'(n_strobe), 64'd8);
    rd(8'h40, 9'd15, 64'h2_0000_0004);
    rd(8'h38, 9'd16, 64'hCAFE_F00D);
    drain("drain_timeout");
    wr(8'h40, 64'h4);
    rd(8'h40, 9'd17, 64'h2_0000_0000);
    drain("drain_timeout_clr");

    // Malformed commands
    wr(8'h28, 64'h0300_0000);
    repeat (2) begin
      chk("errcmd_both_nostrobe", 64'(mgmt_read | mgmt_write), 64'h0);
      @(negedge clk);
    end
    rd(8'h40, 9'd18, 64'h2_0000_0010);
    drain("drain_errcmd_both");
    wr(8'h40, 64'h10);
    rd(8'h40, 9'd19, 64'h2_0000_0000);
    drain("drain_errcmd_clr");
    wr(8'h28, 64'h0104_0000);
    repeat (2) begin
      chk("errcmd_ch_nostrobe", 64'(mgmt_read | mgmt_write), 64'h0);
      @(negedge clk);
    end
    rd(8'h40, 9'd24, 64'h2_0000_0010);
    drain("drain_errcmd_ch");
    wr(8'h40, 64'h10);

    // Command while busy, with the timeout disabled
    wr(8'h50, 64'd0);
    wr(8'h28, 64'h0202_0077);
    chk("busy_strobe", 64'(mgmt_write), 64'h4);
    chk("busy_address", 64'(mgmt_address), 64'h77);
    chk("busy_writedata", 64'(mgmt_writedata), 64'h1234);
    wr(8'h28, 64'h0100_0005);
    rd(8'h40, 9'd25, 64'h2_0000_0009);
    drain("drain_busy_status");
    repeat (20) @(negedge clk);
    chk("busy_strobe_kept", 64'(mgmt_write), 64'h4);
    chk("busy_no_read", 64'(mgmt_read), 64'h0);
    chk("busy_address_kept", 64'(mgmt_address), 64'h77);
    chk("busy_writedata_kept", 64'(mgmt_writedata), 64'h1234);
    mgmt_waitrequest[2] = 1'b0;
    @(negedge clk);
    chk("busy_strobe_drop", 64'(mgmt_write), 64'h0);
    mgmt_waitrequest = '1;
    rd(8'h40, 9'd26, 64'h3_0000_000A);
    rd(8'h28, 9'd27, 64'h0100_0005);
    drain("drain_busy_done");

    // Asynchronous reset in the middle of a transaction with a response in flight
    wr(8'h28, 64'h0100_0000);
    chk("prerst_strobe", 64'(mgmt_read), 64'h1);
    mmio_rd_en = 1'b1;
    mmio_addr  = 16'h0010;
    mmio_tid   = 9'h055;
    @(negedge clk);
    mmio_rd_en = 1'b0;
    @(posedge clk);
    #2;
    chk("prerst_rsp_valid", 64'(mmio_rsp_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 64'(mmio_rsp_valid), 64'd0);
    chk("async_rst_mgmt_read", 64'(mgmt_read), 64'h0);
    chk("async_rst_mgmt_write", 64'(mgmt_write), 64'h0);
    chk("async_rst_rsp_data", mmio_rsp_data, 64'd0);
    chk("async_rst_address", 64'(mgmt_address), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(8'h40, 9'd30, 64'd0);
    rd(8'h50, 9'd31, 64'd1024);
    rd(8'h38, 9'd32, 64'd0);
    rd(8'h28, 9'd33, 64'd0);
    rd(8'h48, 9'd34, 64'd0);
    drain("drain_post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_mgmt_csr_bridge.md
ETH_MGMT_CSR_BRIDGE -- requirements
Module: eth_mgmt_csr_bridge

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of Ethernet management channels, 1..256.
REQ-002 SHALL have parameter ADDR_W, default 16: management address width, 1..16.
REQ-003 SHALL have parameter DATA_W, default 32: management data width, 1..64.
REQ-004 SHALL have parameter TIMEOUT_RST, default 1024: reset value of TIMEOUT register.
REQ-005 SHALL have parameters AFU_ID_L / AFU_ID_H, 64-bit each, defaults 64'h0: returned at ID CSRs.
REQ-006 clk  in  1  sole clock; one clock; reset is asynchronous and active-low.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 mmio_wr_en  in  1  MMIO write strobe, one cycle.
REQ-009 mmio_rd_en  in  1  MMIO read strobe, one cycle.
REQ-010 mmio_addr  in  16  CCI-P 4B address; bits [15:1] are the 8B index.
REQ-011 mmio_wdata  in  64  write data.
REQ-012 mmio_tid  in  9  read transaction ID.
REQ-013 mmio_rsp_valid / mmio_rsp_tid / mmio_rsp_data  out  1/9/64  read response.
REQ-014 mgmt_address  out  ADDR_W  shared management address.
REQ-015 mgmt_writedata  out  DATA_W  shared write data.
REQ-016 mgmt_read / mgmt_write  out  NUM_CH each  per-channel strobes.
REQ-017 mgmt_readdata  in  NUM_CH*DATA_W  channel c at slice [c*DATA_W +: DATA_W].
REQ-018 mgmt_waitrequest  in  NUM_CH  per-channel stall.

Function
REQ-019 CSR map (byte offset): 0x00 DFH=64'h1000000000000001, 0x08 ID_L, 0x10 ID_H, 0x28 CMD, 0x30 WR_DATA, 0x38 RD_DATA (RO), 0x40 STATUS, 0x48 SCRATCH, 0x50 TIMEOUT; all other offsets read 0, writes ignored.
REQ-020 CMD fields: [ADDR_W-1:0] addr, [23:16] channel, [24] read, [25] write; a CMD write is the trigger, and CMD also reads back its last written value.
REQ-021 STATUS: [0] busy, [1] done, [2] err_timeout, [3] err_busy, [4] err_cmd, [47:32] completed-transaction count (wraps at 16'hFFFF->0); bits [4:2] write-1-to-clear, others RO.
REQ-022 Read response SHALL assert mmio_rsp_valid exactly 2 clk after mmio_rd_en, with the matching tid and the data sampled at the cycle after the strobe; back-to-back reads every cycle SHALL be supported.
REQ-023 FSM states IDLE, BUSY.
REQ-024 IDLE->BUSY on a CMD write with exactly one of read/write set and channel<NUM_CH: clear done, load address/writedata, assert strobe on the selected channel the next cycle.
REQ-025 CMD write in IDLE with both/neither op bits or channel>=NUM_CH SHALL set err_cmd, issue nothing, and stay IDLE.
REQ-026 CMD write while BUSY (including the completion cycle) SHALL be dropped and set err_busy.
REQ-027 In BUSY, strobe held with address/data stable; the first cycle the selected mgmt_waitrequest is low completes: read captures readdata zero-extended into RD_DATA, done=1, count+1, ->IDLE, strobe deasserted next cycle.
REQ-028 BUSY cycle counter starts at 0; if TIMEOUT!=0 and counter reaches TIMEOUT without completion: deassert strobe, set err_timeout, done stays 0, count unchanged, RD_DATA unchanged, ->IDLE; TIMEOUT=0 disables timeout.
REQ-029 At most one bit of mgmt_read|mgmt_write SHALL be high at any cycle.
REQ-030 WR_DATA write while BUSY SHALL update the register but not mgmt_writedata of the active transaction.

Reset
REQ-031 On reset_n low, immediately: FSM IDLE, all strobes 0, mmio_rsp_valid 0, every CSR and STATUS bit 0, counters 0, TIMEOUT=TIMEOUT_RST; reset mid-transaction SHALL abort it with no completion recorded.
REQ-032 mmio_rsp_tid, mmio_rsp_data, mgmt_address, mgmt_writedata SHALL also reset to 0.

Structure
REQ-033 Shared package eth_mgmt_csr_pkg SHALL hold CSR offset constants, CMD/STATUS field positions, and the FSM state enum.
REQ-034 One sub-module eth_mgmt_txn_fsm SHALL implement REQ-023..029, with the CSR decode and read pipeline in the top module.

Verification
REQ-035 Write CMD=0x0100_0012, channel 0 read, waitrequest low after 3 cycles with readdata=0xCAFEF00D -> RD_DATA=0xCAFEF00D, STATUS=0x1_00000002.
REQ-036 NUM_CH=4, write WR_DATA=0x55AA, CMD=0x0203_0040 -> only mgmt_write[3] high, address 0x40, writedata 0x55AA until waitrequest low.
REQ-037 TIMEOUT=8, channel 1 waitrequest stuck high -> strobe drops after 8 BUSY cycles, STATUS[2]=1, count 0; write STATUS=0x4 -> bit clears.
REQ-038 CMD=0x0300_0000 (both ops) or channel 0x04 -> err_cmd=1, no strobe; CMD during BUSY -> err_busy=1, original transaction completes unchanged.
REQ-039 Reads of 0x00/0x08/0x48 on consecutive cycles with tids 1,2,3 -> three responses on consecutive cycles, 2-cycle latency, matching tids and data.
REQ-040 reset_n pulsed low in BUSY -> strobes, STATUS, and rsp_valid are 0 asynchronously, and TIMEOUT reads TIMEOUT_RST.
